// File: rtl/crc32_pkg.sv
// ============================================================================
// crc32_pkg : shared CRC-32 constants, frame state type, byte-update function
// Rev 1.0
// ============================================================================
`default_nettype none

package crc32_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_FCS  = 2'd2
  } frame_state_e;

  // Reflected (LSB-first) update: one data byte folded in per call.
  function automatic logic [31:0] crc32_next_byte(input logic [31:0] crc,
                                                  input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc32_byte_engine.sv
// ============================================================================
// crc32_byte_engine : 32-bit CRC register, init has priority over byte update
// Rev 1.0
// ============================================================================
`default_nettype none

module crc32_byte_engine
  import crc32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = CRC32_INIT;
    end else if (en) begin
      crc_d = crc32_next_byte(crc_q, data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

`default_nettype wire

// File: rtl/crc32_frame_ctrl.sv
// ============================================================================
// crc32_frame_ctrl : payload pass-through with 4-byte CRC-32 FCS appended.
// Optional completed-frame counter enabled by macro CRC32_FRAME_CNT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module crc32_frame_ctrl
  import crc32_pkg::*;
#(
  parameter int FCS_MSB_FIRST = 0,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last
`ifdef CRC32_FRAME_CNT_EN
  ,
  output logic [CNT_W-1:0] frame_cnt
`endif
);

  frame_state_e state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [31:0]  crc;
  logic [31:0]  fcs_word;
  logic [1:0]   fcs_sel;
  logic [7:0]   fcs_byte;
  logic         crc_en;
  logic         frame_done;

  crc32_byte_engine u_engine (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (frame_done),
    .en    (crc_en),
    .data  (in_data),
    .crc   (crc)
  );

  assign fcs_word = crc ^ CRC32_XOROUT;

  generate
    if (FCS_MSB_FIRST != 0) begin : g_fcs_msb_first
      assign fcs_sel = 2'd3 - idx_q;
    end else begin : g_fcs_lsb_first
      assign fcs_sel = idx_q;
    end
  endgenerate

  always_comb begin
    fcs_byte = fcs_word[7:0];
    case (fcs_sel)
      2'd0:    fcs_byte = fcs_word[7:0];
      2'd1:    fcs_byte = fcs_word[15:8];
      2'd2:    fcs_byte = fcs_word[23:16];
      default: fcs_byte = fcs_word[31:24];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    in_ready   = out_ready;
    out_valid  = in_valid;
    out_data   = in_data;
    out_last   = 1'b0;
    crc_en     = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (in_valid && out_ready) begin
          crc_en  = 1'b1;
          state_d = in_last ? ST_FCS : ST_DATA;
        end
      end
      ST_FCS: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        out_data  = fcs_byte;
        out_last  = (idx_q == 2'd3);
        if (out_ready) begin
          // idx wraps 3 -> 0, leaving it ready for the next frame
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

`ifdef CRC32_FRAME_CNT_EN
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_done) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc32_frame_ctrl.sv
// ============================================================================
// tb_crc32_frame_ctrl : directed bench for crc32_frame_ctrl (both FCS orders)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_crc32_frame_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic       in_ready,  in_ready_m;
  logic       out_valid, out_valid_m;
  logic [7:0] out_data,  out_data_m;
  logic       out_last,  out_last_m;
`ifdef CRC32_FRAME_CNT_EN
  logic [15:0] frame_cnt, frame_cnt_m;
`endif

  int checks;
  int failures;
  int exp_frames;
  logic [7:0] pay [0:8];

  crc32_frame_ctrl #(.FCS_MSB_FIRST(0), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
`ifdef CRC32_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  crc32_frame_ctrl #(.FCS_MSB_FIRST(1), .CNT_W(16)) dut_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_m),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid_m),
    .out_ready (out_ready),
    .out_data  (out_data_m),
    .out_last  (out_last_m)
`ifdef CRC32_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt_m)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Streams nfr frames of pay[0:plen-1]; in_valid stays high throughout so the
  // next frame's first byte is presented (and must be refused) during FCS.
  task automatic run(input int plen, input logic [31:0] fcs, input int nfr, input bit toggle);
    int ptr;
    int cyc;
    int total;
    int phase;
    int k;
    logic ordy;
    ptr   = 0;
    cyc   = 0;
    total = nfr * (plen + 4);
    while (ptr < total && cyc < 400) begin
      phase     = ptr % (plen + 4);
      ordy      = toggle ? ((cyc % 2) == 0) : 1'b1;
      out_ready = ordy;
      in_valid  = 1'b1;
      in_data   = (phase < plen) ? pay[phase] : pay[0];
      in_last   = (phase == plen - 1);
      #1;
      chk("out_valid", out_valid, 1);
      chk("out_valid_msb", out_valid_m, 1);
      if (phase < plen) begin
        chk("pay_data", out_data, pay[phase]);
        chk("pay_data_msb", out_data_m, pay[phase]);
        chk("pay_in_ready", in_ready, ordy);
        chk("pay_out_last", out_last, 0);
      end else begin
        k = phase - plen;
        chk("fcs_data", out_data, fcs[8*k +: 8]);
        chk("fcs_data_msb", out_data_m, fcs[8*(3-k) +: 8]);
        chk("fcs_in_ready", in_ready, 0);
        chk("fcs_out_last", out_last, (k == 3));
        chk("fcs_out_last_msb", out_last_m, (k == 3));
      end
      if (ordy) begin
        ptr++;
        if (phase == plen + 3) exp_frames++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("handshakes", ptr, total);
    if (!toggle) chk("cycles", cyc, total);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_frames = 0;
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
`ifdef CRC32_FRAME_CNT_EN
    chk("rst_frame_cnt", frame_cnt, 0);
`endif
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready_bp", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    #1;
    chk("rst_out_valid_iv", out_valid, 1);
    chk("rst_out_data", out_data, 8'hA5);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // "123456789", no backpressure
    run(9, 32'hCBF4_3926, 1, 1'b0);

    // single 0x00 byte
    pay[0] = 8'h00;
    run(1, 32'hD202_EF8D, 1, 1'b0);
    pay[0] = 8'h31;

    // out_ready toggling every cycle
    run(9, 32'hCBF4_3926, 1, 1'b1);

    // back-to-back frames
    run(9, 32'hCBF4_3926, 2, 1'b0);
`ifdef CRC32_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, exp_frames);
    chk("frame_cnt_msb", frame_cnt_m, exp_frames);
`endif

    // reset after two FCS bytes
    for (int i = 0; i < 9; i++) begin
      in_valid  = 1'b1;
      in_data   = pay[i];
      in_last   = (i == 8);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    chk("pre_rst_fcs0", out_data, 8'h26);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_rst_fcs2", out_data, 8'hF4);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_last", out_last, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    out_ready = 1'b0;
    #1;
    chk("midrst_pass_data", out_data, 8'h5A);
    chk("midrst_pass_valid", out_valid, 1);
    chk("midrst_in_ready_bp", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    exp_frames = 0;
`ifdef CRC32_FRAME_CNT_EN
    chk("midrst_frame_cnt", frame_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(9, 32'hCBF4_3926, 1, 1'b0);
`ifdef CRC32_FRAME_CNT_EN
    chk("post_rst_frame_cnt", frame_cnt, exp_frames);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/crc32_frame_ctrl.md
# crc32_frame_ctrl

Frame controller that sequences the byte-parallel CRC-32 datapath for a transmit byte stream. Passes payload bytes through unchanged, feeds each accepted byte into the CRC register, and appends the 4-byte FCS after the byte flagged last. Sits between a payload source and the line/serializer side; owns CRC init, update and finish so upstream never drives CRC load/finish strobes directly.

## Interface
Parameters:
- `FCS_MSB_FIRST`, default 0: 0 emits FCS byte [7:0] first (Ethernet order); 1 emits byte [31:24] first.
- `CNT_W`, default 16: width of the frame counter (only used under the configuration macro).

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous reset, active-low.
- `in_valid`  in  1  upstream byte valid.
- `in_ready`  out  1  upstream byte accepted when `in_valid && in_ready`.
- `in_data`  in  8  payload byte.
- `in_last`  in  1  marks the final payload byte of the frame.
- `out_valid`  out  1  downstream byte valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  8  payload or FCS byte.
- `out_last`  out  1  high only on the final FCS byte.
- `frame_cnt`  out  CNT_W  completed-frame count (present only with `CRC32_FRAME_CNT_EN`).

## Operation
- CRC-32: reflected poly 0x04C11DB7 (0xEDB88320 reflected), init 0xFFFFFFFF, final XOR 0xFFFFFFFF, one byte per update.
- States: IDLE, DATA, FCS.
- IDLE: crc reg held at 0xFFFFFFFF; `in_ready = out_ready`; `out_valid = in_valid`; `out_data = in_data`. On handshake: crc updates with `in_data`; go to DATA, or to FCS if `in_last`.
- DATA: same pass-through; crc updates on each handshake; `in_last` handshake goes to FCS.
- FCS: `in_ready = 0`; `out_valid = 1`; `out_data` = byte `idx` of `~crc` (order per `FCS_MSB_FIRST`); 2-bit `idx` advances on `out_ready`; `out_last = (idx == 3)`. On handshake at idx 3: go to IDLE, crc reinitialized, `idx` = 0.
- `out_last` is 0 in IDLE/DATA, even when `in_last` = 1.
- Minimum frame: 1 payload byte. Empty frames are not possible.
- `in_data` / `in_last` are ignored without a handshake.
- Reset value:
  - state IDLE, crc 0xFFFFFFFF, idx 0, `frame_cnt` 0.
  - Outputs from reset: `in_ready = out_ready`, `out_valid = in_valid`, `out_last = 0`.
- Reset mid-frame: frame is discarded, there is no partial FCS, and the next accepted byte starts a fresh frame.

## Timing
- Payload path is combinational: zero latency from input handshake to output.
- `in_ready` depends combinationally on `out_ready`. `out_valid` never depends on `out_ready`.
- First FCS byte is valid the cycle after the `in_last` handshake.
- FCS takes exactly 4 output handshakes. Under backpressure, `out_data` and `idx` hold stable.
- Back-to-back frames: the next frame's first byte is accepted no earlier than the cycle after the idx-3 handshake.
- Throughput: N payload bytes take N+4 handshake cycles.

## Configuration
- `CRC32_FRAME_CNT_EN` defined:
  - `frame_cnt` port exists.
  - Increments on each idx-3 FCS handshake.
  - Wraps from 2^CNT_W−1 to 0.
  - Reset to 0.
- Not defined: port and counter logic are absent, and all other behaviour is identical.

## Structure
- Shared package `crc32_pkg`:
  - `CRC32_POLY_REFL` = 0xEDB88320
  - `CRC32_INIT` = 0xFFFFFFFF
  - `CRC32_XOROUT` = 0xFFFFFFFF
  - state enum typedef
  - pure function `crc32_next_byte(crc[31:0], data[7:0])`
- Sub-module `crc32_byte_engine`: holds the 32-bit register, with `init` and `en` inputs and the `data[7:0]` input. The controller instantiates one.

## Test plan
- "123456789" (0x31..0x39), `in_last` on 0x39, `out_ready` = 1: 9 payload bytes pass, then 0x26 0x39 0xF4 0xCB. `out_last` only on 0xCB. 13 output handshakes total.
- Single byte 0x00 with `in_last`: FCS 0x8D 0xEF 0x02 0xD2.
- "123456789" with `out_ready` toggling 1/0 every cycle during payload and FCS: identical byte sequence, with no duplicate or skipped byte. `in_ready` is 0 whenever `out_ready` is 0.
- Two back-to-back "123456789" frames with `in_valid` held high: second frame's 0x31 accepted only after the first 0xCB handshake. Both FCS equal 0xCBF43926. With macro: `frame_cnt` = 2.
- `rst_n` pulsed low after 2 FCS bytes: `out_last` = 0 and state IDLE immediately. A following "123456789" frame yields FCS 0xCBF43926.
- `FCS_MSB_FIRST` = 1 with "123456789": FCS bytes 0xCB 0xF4 0x39 0x26.
